// File: rtl/vga_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : vga_stream_sink
//  Purpose  : Avalon-ST 30-bit video sink that buffers pixels in a small FIFO,
//             locks to frame boundaries and drives registered VGA timing/colour.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_stream_sink #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] data,
   input  logic        startofpacket,
   input  logic        endofpacket,
   input  logic        valid,
   output logic        ready,
   output logic [9:0]  vga_r,
   output logic [9:0]  vga_g,
   output logic [9:0]  vga_b,
   output logic        vga_hs_n,
   output logic        vga_vs_n,
   output logic        vga_blank_n,
   output logic        locked,
   output logic        underflow,
   output logic        frame_err
);

   localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_hw      = $clog2(c_h_total + 1);
   localparam int c_vw      = $clog2(c_v_total + 1);
   localparam int c_aw      = $clog2(FIFO_DEPTH);
   localparam int c_cw      = c_aw + 1;

   localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_total - 1);
   localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
   localparam logic [c_hw-1:0] c_h_lpix  = c_hw'(H_ACTIVE - 1);
   localparam logic [c_hw-1:0] c_hs_beg  = c_hw'(H_ACTIVE + H_FP);
   localparam logic [c_hw-1:0] c_hs_end  = c_hw'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_total - 1);
   localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
   localparam logic [c_vw-1:0] c_v_lline = c_vw'(V_ACTIVE - 1);
   localparam logic [c_vw-1:0] c_vs_beg  = c_vw'(V_ACTIVE + V_FP);
   localparam logic [c_vw-1:0] c_vs_end  = c_vw'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [c_cw-1:0] c_depth   = c_cw'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_SEEK   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // FIFO word layout: {sop, eop, pixel}
   logic [31:0]     mem_q [FIFO_DEPTH];
   logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
   logic [c_cw-1:0] count_q;
   logic            rst_q;
   logic            w_push, w_pop, w_empty;
   logic [31:0]     w_head;

   logic [c_hw-1:0] h_q;
   logic [c_vw-1:0] v_q;
   logic            w_active, w_first, w_last, w_hs, w_vs;

   state_t          state_q, state_d;
   logic [29:0]     pix_d, rgb_q;
   logic            underflow_d, frame_err_d;
   logic            hs_n_q, vs_n_q, blank_n_q, underflow_q, frame_err_q;

   // rst_q keeps ready low for the first cycle after reset is released
   assign ready   = ~reset & ~rst_q & (count_q < c_depth);
   assign w_push  = valid & ready;
   assign w_empty = (count_q == '0);
   assign w_head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {startofpacket, endofpacket, data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rst_q    <= 1'b1;
      end else begin
         rst_q <= 1'b0;
         if (w_push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + c_cw'(1);
            2'b01:   count_q <= count_q - c_cw'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else if (h_q == c_h_last) begin
         h_q <= '0;
         v_q <= (v_q == c_v_last) ? '0 : v_q + c_vw'(1);
      end else begin
         h_q <= h_q + c_hw'(1);
      end
   end

   assign w_active = (h_q < c_h_act) && (v_q < c_v_act);
   assign w_first  = (h_q == '0) && (v_q == '0);
   assign w_last   = (h_q == c_h_lpix) && (v_q == c_v_lline);
   assign w_hs     = (h_q >= c_hs_beg) && (h_q < c_hs_end);
   assign w_vs     = (v_q >= c_vs_beg) && (v_q < c_vs_end);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_SEEK;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      w_pop       = 1'b0;
      pix_d       = '0;
      underflow_d = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_SEEK: begin
            if (!w_empty) begin
               if (!w_head[31]) begin
                  w_pop = 1'b1;
               end else if (w_first) begin
                  w_pop   = 1'b1;
                  pix_d   = w_head[29:0];
                  state_d = ST_LOCKED;
                  if (w_head[30] != w_last) begin
                     frame_err_d = 1'b1;
                     state_d     = ST_SEEK;
                  end
               end
            end
         end
         ST_LOCKED: begin
            if (w_active) begin
               if (w_empty) begin
                  underflow_d = 1'b1;
                  state_d     = ST_SEEK;
               end else begin
                  w_pop = 1'b1;
                  if (w_head[31] && !w_first) begin
                     frame_err_d = 1'b1;
                     state_d     = ST_SEEK;
                  end else begin
                     // an eop anywhere but the last pixel, or a missing one there
                     pix_d = w_head[29:0];
                     if (w_head[30] != w_last) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_SEEK;
                     end
                  end
               end
            end
         end
         default: state_d = ST_SEEK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q       <= '0;
         hs_n_q      <= 1'b1;
         vs_n_q      <= 1'b1;
         blank_n_q   <= 1'b0;
         underflow_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rgb_q       <= pix_d;
         hs_n_q      <= ~w_hs;
         vs_n_q      <= ~w_vs;
         blank_n_q   <= w_active;
         underflow_q <= underflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign vga_r       = rgb_q[29:20];
   assign vga_g       = rgb_q[19:10];
   assign vga_b       = rgb_q[9:0];
   assign vga_hs_n    = hs_n_q;
   assign vga_vs_n    = vs_n_q;
   assign vga_blank_n = blank_n_q;
   assign locked      = (state_q == ST_LOCKED);
   assign underflow   = underflow_q;
   assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
- Avalon-ST video sink: accepts the 30-bit pixel stream (10b R/G/B, with sop/eop framing) and drives VGA timing and colour outputs.
- Sits downstream of the pixel source/filter chain and upstream of the DAC pins.
- Buffers input in a small FIFO, locks to frame boundaries and recovers from underflow or framing errors.
- clk is the pixel clock: one pixel per cycle in the active region.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
FIFO_DEPTH, 16, input FIFO entries (power of 2, >=4)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
data  in  30  pixel {R[29:20], G[19:10], B[9:0]}
startofpacket  in  1  first pixel of frame
endofpacket  in  1  last pixel of frame
valid  in  1  source data valid
ready  out  1  sink can accept
vga_r  out  10  red
vga_g  out  10  green
vga_b  out  10  blue
vga_hs_n  out  1  hsync, active low
vga_vs_n  out  1  vsync, active low
vga_blank_n  out  1  high during active video
locked  out  1  high while in LOCKED state
underflow  out  1  1-cycle pulse on FIFO underflow
frame_err  out  1  1-cycle pulse on sop/eop violation

Behaviour:
- Reset: h_cnt=v_cnt=0, FIFO empty, state=SEEK. Outputs during reset and on the first cycle after it: ready=0, rgb=0, hs_n=vs_n=1, blank_n=0, locked=0, underflow=frame_err=0.
- ready = ~reset & (count < FIFO_DEPTH). A word {sop, eop, data} is pushed when valid & ready. Push and pop in the same cycle leave count unchanged.
- Timing counters:
  - h_cnt runs 0..H_TOTAL-1 every cycle. On wrap, v_cnt advances 0..V_TOTAL-1.
  - active = h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Output pipeline: all VGA outputs are registered together, with 1-cycle latency from the counter values. Sync, blank and colour stay aligned.
- State SEEK:
  - At any time, pop and discard a head word with sop=0.
  - A head word with sop=1 is held, not popped.
  - Colour outputs 0.
  - Transition to LOCKED on the cycle h_cnt=0 & v_cnt=0 with sop=1 at the head. That word is popped as pixel (0,0) in that same cycle.
- State LOCKED: pop exactly one word per active cycle. Colour = popped data. Blanking cycles output 0 and never pop.
  - FIFO empty on an active cycle: pixel 0, underflow pulse, go to SEEK.
  - Popped word has sop=1 at any pixel other than (0,0): frame_err pulse, pixel 0, go to SEEK. The word is consumed.
  - Popped word has eop=1 at any pixel other than (H_ACTIVE-1, V_ACTIVE-1): frame_err, go to SEEK. The pixel is still displayed.
  - Last pixel popped with eop=0: frame_err, go to SEEK.
  - Last pixel with eop=1: remain LOCKED.
- After a drop to SEEK, the rest of the frame is black. The earliest relock is the next frame start.
- Reset mid-frame: immediate return to reset values. The FIFO is flushed.
- underflow and frame_err never assert in the same cycle. Underflow takes priority because no word exists.

Test Plan (use H_ACTIVE=4,H_FP=1,H_SYNC=1,H_BP=1,V_ACTIVE=2,V_FP=1,V_SYNC=1,V_BP=1, FIFO_DEPTH=4):
1. Reset held 3 cycles, then released with valid=0 -> ready=1, hs_n=vs_n=1, blank_n=0, rgb=0. Measure: H_TOTAL=7, V_TOTAL=5. hs_n low 1 cycle per line at h_cnt=5, seen on the output one cycle later. vs_n low for all of line 3.
2. Stream 8 pixels in sequence, data=i (i=0..7), sop on i=0 and eop on i=7, starting before frame start -> locked rises at frame start. vga_b shows 0,1,2,3 on line 0 and 4,5,6,7 on line 1. No error pulses. Second identical frame keeps locked=1.
3. Sink stalled: push 4 words while frame has not started -> ready=0 once count=4. No word is accepted while ready=0. The first word is popped at (0,0) and ready returns high on the next cycle.
4. Mid-frame starvation: only 5 of the 8 pixels sent -> underflow pulses at line 1, pixel 1. locked=0, remaining pixels are 0, and relock occurs on the next frame once sop arrives.
5. Framing faults: sop on pixel 3 -> frame_err at (3,0), SEEK. eop missing on pixel 7 -> frame_err at (3,1).
6. Garbage before sop: 3 words without sop, then a valid frame -> the 3 words are discarded and the frame displays correctly from the next frame start.
